// File: rtl/haraka_sponge_ctrl.sv
// rtl/haraka_sponge_ctrl.sv - Haraka-S sponge absorb/permute/squeeze sequencing FSM
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   blk_valid/blk_last  padded rate block offered by deserializer (last = final block)
//   blk_ready           block accepted this cycle (IDLE/ABSORB only)
//   digest_length       output length in bytes, latched on the last-block handshake
//   absorb_load         pulse: xor block into rate part of state
//   perm_start          one-cycle start pulse to the Haraka core
//   round               round-constant index 0..ROUNDS-1
//   round_done          pulse from core: current round finished
//   state_capture       pulse: state <= core output
//   sq_valid/sq_len     rate block and its valid byte count offered to serializer
//   sq_ready            serializer accepts the offered block
//   busy                high whenever not IDLE
//   done                one-cycle pulse when the message is fully processed

module haraka_sponge_ctrl #(
    parameter int RATE_BYTES = 32,
    parameter int ROUNDS     = 5,
    parameter int LEN_W      = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             blk_valid,
    input  logic             blk_last,
    output logic             blk_ready,
    input  logic [LEN_W-1:0] digest_length,
    output logic             absorb_load,
    output logic             perm_start,
    output logic [2:0]       round,
    input  logic             round_done,
    output logic             state_capture,
    output logic             sq_valid,
    output logic [5:0]       sq_len,
    input  logic             sq_ready,
    output logic             busy,
    output logic             done
);

    localparam int               OFF_W      = $clog2(RATE_BYTES);
    localparam logic [LEN_W-1:0] OFF_MASK   = LEN_W'(RATE_BYTES - 1);
    localparam logic [2:0]       LAST_ROUND = 3'(ROUNDS - 1);
    localparam logic [5:0]       FULL_LEN   = 6'(RATE_BYTES);

    typedef enum logic [3:0] {
        IDLE,
        ABSORB,
        PERM_START,
        PERM_RUN,
        CAPTURE,
        SQ_EMIT,
        SQ_PERM_START,
        SQ_PERM_RUN,
        SQ_CAPTURE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       round_q, round_d;
    logic             last_q, last_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;

    // Block-count arithmetic: (len >> log2(rate)) + (remainder != 0) cannot
    // overflow LEN_W, unlike the usual (len + rate - 1) >> log2(rate) form.
    logic [LEN_W-1:0] rem;
    logic             rem_nz;
    logic [LEN_W-1:0] nblk;
    logic             is_last_blk;

    assign rem         = len_q & OFF_MASK;
    assign rem_nz      = (rem != '0);
    assign nblk        = (len_q >> OFF_W) + {{(LEN_W-1){1'b0}}, rem_nz};
    // Only evaluated in SQ_EMIT, where len_q != 0 guarantees nblk >= 1.
    assign is_last_blk = (idx_q == nblk - LEN_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= '0;
            last_q  <= 1'b0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            last_q  <= last_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        round_d       = round_q;
        last_d        = last_q;
        len_d         = len_q;
        idx_d         = idx_q;
        blk_ready     = 1'b0;
        absorb_load   = 1'b0;
        perm_start    = 1'b0;
        state_capture = 1'b0;
        sq_valid      = 1'b0;
        sq_len        = 6'd0;
        done          = 1'b0;

        case (state_q)
            IDLE, ABSORB: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    absorb_load = 1'b1;
                    last_d      = blk_last;
                    idx_d       = '0;
                    if (blk_last) begin
                        len_d = digest_length;
                    end
                    state_d = PERM_START;
                end
            end

            PERM_START, SQ_PERM_START: begin
                perm_start = 1'b1;
                round_d    = '0;
                state_d    = (state_q == PERM_START) ? PERM_RUN : SQ_PERM_RUN;
            end

            PERM_RUN, SQ_PERM_RUN: begin
                if (round_done) begin
                    if (round_q == LAST_ROUND) begin
                        round_d = '0;
                        state_d = (state_q == PERM_RUN) ? CAPTURE : SQ_CAPTURE;
                    end else begin
                        round_d = round_q + 3'd1;
                    end
                end
            end

            CAPTURE: begin
                state_capture = 1'b1;
                if (!last_q) begin
                    state_d = ABSORB;
                end else if (len_q == '0) begin
                    // Zero-length digest: nothing to squeeze, finish here.
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = SQ_EMIT;
                end
            end

            SQ_CAPTURE: begin
                state_capture = 1'b1;
                state_d       = SQ_EMIT;
            end

            SQ_EMIT: begin
                sq_valid = 1'b1;
                sq_len   = (is_last_blk && rem_nz) ? 6'(rem) : FULL_LEN;
                if (sq_ready) begin
                    if (is_last_blk) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = SQ_PERM_START;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign round = round_q;
    assign busy  = (state_q != IDLE);

endmodule
